// File: rtl/e203_exu_bjp_resolve.sv
// Branch/jump resolver: compares the IFU's predicted taken bit with the ALU's result and
// asks the IFU to flush and redirect on a mispredict. Also keeps saturating branch statistics.
module e203_exu_bjp_resolve #(
  parameter int PC_SIZE = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmt_i_valid,
  output logic               cmt_i_ready,
  input  logic               cmt_i_bjp,
  input  logic [PC_SIZE-1:0] cmt_i_pc,
  input  logic               cmt_i_rv32,
  input  logic [PC_SIZE-1:0] cmt_i_imm,
  input  logic               cmt_i_bjp_prdt,
  input  logic               cmt_i_bjp_rslv,
  output logic               brchmis_flush_req,
  input  logic               brchmis_flush_ack,
  output logic [PC_SIZE-1:0] brchmis_flush_add_op1,
  output logic [PC_SIZE-1:0] brchmis_flush_add_op2,
  output logic               cmt_mis,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   stat_bjp_cnt,
  output logic [CNT_W-1:0]   stat_mis_cnt,
  output logic               dbg_state
);

  // Handshake: an instruction is taken on any rising edge where cmt_i_valid and cmt_i_ready
  // are both high; the upstream must hold its payload stable while valid is high and ready is low.

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_acc;
  logic               w_mis;
  logic [PC_SIZE-1:0] w_op2_nxt;
  logic [PC_SIZE-1:0] r_op1;
  logic [PC_SIZE-1:0] r_op2;
  logic               r_cmt_mis;
  logic [CNT_W-1:0]   r_bjp_cnt;
  logic [CNT_W-1:0]   r_mis_cnt;

  assign w_acc = cmt_i_valid & cmt_i_ready;
  assign w_mis = w_acc & cmt_i_bjp & (cmt_i_bjp_prdt != cmt_i_bjp_rslv);

  // Predicted taken but actually falls through: redirect to the next sequential PC.
  always_comb begin
    w_op2_nxt = cmt_i_imm;
    if (cmt_i_bjp_prdt) begin
      w_op2_nxt = cmt_i_rv32 ? PC_SIZE'(4) : PC_SIZE'(2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_mis) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (brchmis_flush_ack) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmt_i_ready       = 1'b0;
    brchmis_flush_req = 1'b0;
    case (r_state)
      ST_IDLE:  cmt_i_ready       = 1'b1;
      ST_FLUSH: brchmis_flush_req = 1'b1;
      default:  cmt_i_ready       = 1'b0;
    endcase
  end

  // Operands only change on a new mispredict, so they stay stable for the whole flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op1     <= '0;
      r_op2     <= '0;
      r_cmt_mis <= 1'b0;
    end else begin
      r_cmt_mis <= w_mis;
      if (w_mis) begin
        r_op1 <= cmt_i_pc;
        r_op2 <= w_op2_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      r_bjp_cnt <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_acc && cmt_i_bjp && (r_bjp_cnt != {CNT_W{1'b1}})) begin
        r_bjp_cnt <= r_bjp_cnt + CNT_W'(1);
      end
      if (w_mis && (r_mis_cnt != {CNT_W{1'b1}})) begin
        r_mis_cnt <= r_mis_cnt + CNT_W'(1);
      end
    end
  end

  assign brchmis_flush_add_op1 = r_op1;
  assign brchmis_flush_add_op2 = r_op2;
  assign cmt_mis               = r_cmt_mis;
  assign stat_bjp_cnt          = r_bjp_cnt;
  assign stat_mis_cnt          = r_mis_cnt;
  assign dbg_state             = r_state;

endmodule

// File: tb/tb_e203_exu_bjp_resolve.sv
// Bench for e203_exu_bjp_resolve: directed scenarios followed by random traffic, all checked
// every cycle against a transaction-level reference model.
module tb_e203_exu_bjp_resolve;
  localparam int PW = 32;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmt_i_valid;
  logic          cmt_i_ready;
  logic          cmt_i_bjp;
  logic [PW-1:0] cmt_i_pc;
  logic          cmt_i_rv32;
  logic [PW-1:0] cmt_i_imm;
  logic          cmt_i_bjp_prdt;
  logic          cmt_i_bjp_rslv;
  logic          brchmis_flush_req;
  logic          brchmis_flush_ack;
  logic [PW-1:0] brchmis_flush_add_op1;
  logic [PW-1:0] brchmis_flush_add_op2;
  logic          cmt_mis;
  logic          stat_clr;
  logic [CW-1:0] stat_bjp_cnt;
  logic [CW-1:0] stat_mis_cnt;
  logic          dbg_state;

  e203_exu_bjp_resolve #(.PC_SIZE(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmt_i_valid(cmt_i_valid), .cmt_i_ready(cmt_i_ready), .cmt_i_bjp(cmt_i_bjp),
    .cmt_i_pc(cmt_i_pc), .cmt_i_rv32(cmt_i_rv32), .cmt_i_imm(cmt_i_imm),
    .cmt_i_bjp_prdt(cmt_i_bjp_prdt), .cmt_i_bjp_rslv(cmt_i_bjp_rslv),
    .brchmis_flush_req(brchmis_flush_req), .brchmis_flush_ack(brchmis_flush_ack),
    .brchmis_flush_add_op1(brchmis_flush_add_op1), .brchmis_flush_add_op2(brchmis_flush_add_op2),
    .cmt_mis(cmt_mis), .stat_clr(stat_clr),
    .stat_bjp_cnt(stat_bjp_cnt), .stat_mis_cnt(stat_mis_cnt), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: "is a flush outstanding", the redirect operands, the pulse and two counts.
  bit          m_flush   = 1'b0;
  logic [31:0] m_op1     = '0;
  logic [31:0] m_op2     = '0;
  bit          m_mis     = 1'b0;
  int          m_bjp     = 0;
  int          m_misc    = 0;
  bit          m_last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard step: compare outputs to the model, then advance the model across the next edge.
  task automatic cycle();
    bit acc, mis;
    @(negedge clk);
    chk("ready",     32'(cmt_i_ready),           32'(!m_flush));
    chk("flush_req", 32'(brchmis_flush_req),     32'(m_flush));
    chk("dbg_state", 32'(dbg_state),             32'(m_flush));
    chk("op1",       brchmis_flush_add_op1,      m_op1);
    chk("op2",       brchmis_flush_add_op2,      m_op2);
    chk("cmt_mis",   32'(cmt_mis),               32'(m_mis));
    chk("bjp_cnt",   32'(stat_bjp_cnt),          32'(m_bjp));
    chk("mis_cnt",   32'(stat_mis_cnt),          32'(m_misc));
    acc = cmt_i_valid && !m_flush;
    mis = acc && cmt_i_bjp && (cmt_i_bjp_prdt != cmt_i_bjp_rslv);
    m_last_acc = acc;
    if (rst) begin
      m_flush = 0; m_op1 = '0; m_op2 = '0; m_mis = 0; m_bjp = 0; m_misc = 0;
    end else begin
      m_mis = mis;
      if (stat_clr) begin
        m_bjp = 0; m_misc = 0;
      end else begin
        if (acc && cmt_i_bjp) m_bjp = (m_bjp < CNT_MAX) ? m_bjp + 1 : CNT_MAX;
        if (mis) m_misc = (m_misc < CNT_MAX) ? m_misc + 1 : CNT_MAX;
      end
      if (mis) begin
        m_flush = 1;
        m_op1   = cmt_i_pc;
        m_op2   = cmt_i_bjp_prdt ? (cmt_i_rv32 ? 32'd4 : 32'd2) : cmt_i_imm;
      end else if (m_flush && brchmis_flush_ack) begin
        m_flush = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive(input bit v, input bit bjp, input logic [31:0] pc, input bit rv32,
                       input logic [31:0] imm, input bit prdt, input bit rslv);
    cmt_i_valid = v; cmt_i_bjp = bjp; cmt_i_pc = pc; cmt_i_rv32 = rv32;
    cmt_i_imm = imm; cmt_i_bjp_prdt = prdt; cmt_i_bjp_rslv = rslv;
  endtask

  task automatic idle_in();
    drive(0, 0, '0, 1, '0, 0, 0);
  endtask

  initial begin
    int bjp_before;
    rst = 1; stat_clr = 0; brchmis_flush_ack = 0;
    drive(1, 1, 32'h8000_0000, 1, 32'h10, 0, 1);

    // Reset with valid held high
    cycle(); cycle();
    rst = 0; idle_in();
    cycle();
    chk("rst_ready", 32'(cmt_i_ready), 32'd1);
    chk("rst_flush", 32'(brchmis_flush_req), 32'd0);
    chk("rst_cnt", 32'(stat_bjp_cnt), 32'd0);

    // Correct prediction
    drive(1, 1, 32'h8000_0100, 1, 32'hFFFF_FFF0, 1, 1);
    cycle(); idle_in();
    chk("ok_bjp_cnt", 32'(stat_bjp_cnt), 32'd1);
    chk("ok_mis_cnt", 32'(stat_mis_cnt), 32'd0);
    chk("ok_no_flush", 32'(brchmis_flush_req), 32'd0);

    // Taken mispredict, ack delayed three cycles
    drive(1, 1, 32'h8000_0200, 1, 32'h0000_0040, 0, 1);
    cycle(); idle_in();
    chk("tk_flush", 32'(brchmis_flush_req), 32'd1);
    chk("tk_op1", brchmis_flush_add_op1, 32'h8000_0200);
    chk("tk_op2", brchmis_flush_add_op2, 32'h0000_0040);
    chk("tk_pulse", 32'(cmt_mis), 32'd1);
    repeat (3) cycle();
    chk("tk_hold_op1", brchmis_flush_add_op1, 32'h8000_0200);
    chk("tk_hold_ready", 32'(cmt_i_ready), 32'd0);
    brchmis_flush_ack = 1;
    cycle(); brchmis_flush_ack = 0;
    chk("tk_ack_flush", 32'(brchmis_flush_req), 32'd0);
    chk("tk_ack_ready", 32'(cmt_i_ready), 32'd1);
    chk("tk_mis_cnt", 32'(stat_mis_cnt), 32'd1);

    // Not-taken mispredict, compressed then 4-byte
    drive(1, 1, 32'h8000_0302, 0, 32'h100, 1, 0);
    cycle(); idle_in();
    chk("nt_c_op2", brchmis_flush_add_op2, 32'd2);
    brchmis_flush_ack = 1; cycle(); brchmis_flush_ack = 0;
    drive(1, 1, 32'h8000_0302, 1, 32'h100, 1, 0);
    cycle(); idle_in();
    chk("nt_w_op2", brchmis_flush_add_op2, 32'd4);
    chk("nt_w_op1", brchmis_flush_add_op1, 32'h8000_0302);
    brchmis_flush_ack = 1; cycle(); brchmis_flush_ack = 0;

    // Backpressure: second bjp held during flush, accepted in the first idle cycle
    drive(1, 1, 32'h8000_0400, 1, 32'h20, 0, 1);
    cycle();
    bjp_before = m_bjp;
    drive(1, 1, 32'h8000_0500, 1, 32'h30, 1, 1);
    cycle(); cycle();
    chk("bp_cnt_held", 32'(stat_bjp_cnt), 32'(bjp_before));
    brchmis_flush_ack = 1; cycle(); brchmis_flush_ack = 0;
    chk("bp_cnt_ack", 32'(stat_bjp_cnt), 32'(bjp_before));
    cycle(); idle_in();
    chk("bp_accepted", 32'(stat_bjp_cnt), 32'(bjp_before + 1));

    // Saturate the mispredict counter
    repeat (18) begin
      drive(1, 1, 32'h8000_0600, 1, 32'h8, 0, 1);
      cycle(); idle_in();
      brchmis_flush_ack = 1; cycle(); brchmis_flush_ack = 0;
    end
    chk("sat_mis", 32'(stat_mis_cnt), 32'hF);
    chk("sat_bjp", 32'(stat_bjp_cnt), 32'hF);

    // Clear wins over a simultaneous mispredict
    drive(1, 1, 32'h8000_0700, 1, 32'h8, 0, 1);
    stat_clr = 1;
    cycle(); idle_in(); stat_clr = 0;
    chk("clr_mis", 32'(stat_mis_cnt), 32'd0);
    chk("clr_bjp", 32'(stat_bjp_cnt), 32'd0);
    chk("clr_flush", 32'(brchmis_flush_req), 32'd1);

    // Reset mid-flush discards the flush
    rst = 1; cycle(); rst = 0; cycle();
    chk("rstf_flush", 32'(brchmis_flush_req), 32'd0);
    chk("rstf_ready", 32'(cmt_i_ready), 32'd1);

    // Random traffic; an unaccepted valid keeps its payload
    for (int i = 0; i < 2000; i++) begin
      if (!(cmt_i_valid && !m_last_acc)) begin
        drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
              {$urandom(), 1'b0} , $urandom_range(0, 1), $urandom(),
              $urandom_range(0, 1), $urandom_range(0, 1));
      end
      brchmis_flush_ack = ($urandom_range(0, 9) < 4);
      stat_clr = ($urandom_range(0, 99) < 3);
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 0; stat_clr = 0; idle_in();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
